se_fc_post: RTL and testbench
=============================

Name: se_fc_post

Overview:
- Post-processing stage directly downstream of the SE-block 32-input adder tree and accumulator.
- Takes each completed fully-connected neuron sum and adds the per-neuron bias.
- Applies ReLU after FC1 or hard-sigmoid after FC2, saturates to the datapath width, and emits the result with a neuron address.
- FC1 results feed the FC2 input buffer; FC2 results are the channel scale factors.

Parameters:
BITSIZE, 14, activation/weight/bias word width (signed, Q format with FRAC_BITS fraction bits)
FRAC_BITS, 7, fraction bits of all data words
ACC_W, BITSIZE*2-FRAC_BITS+6, width of incoming accumulated sum (Q FRAC_BITS)
FC1_OUT, 144, number of FC1 neurons per layer pass
FC2_OUT, 576, number of FC2 neurons per layer pass
ADDR_W, 10, neuron address width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
fully_1  in  1  FC1 phase select (level)
fully_2  in  1  FC2 phase select (level)
clear  in  1  synchronous abort: flush pipeline, zero counters
in_sum  in  ACC_W  signed neuron sum, Q FRAC_BITS
in_valid  in  1  in_sum valid, single-cycle qualifier
bias  in  BITSIZE  signed bias for this neuron, same cycle as in_valid
out_data  out  BITSIZE  signed activated result, Q FRAC_BITS
out_valid  out  1  out_data/out_addr valid
out_addr  out  ADDR_W  neuron index of out_data
layer_done  out  1  one-cycle pulse with last neuron of a layer
busy  out  1  any pipeline stage occupied

Behaviour:
- Mode register: fully_1 high sets FC1; else fully_2 high sets FC2; else hold. Both high: FC1 wins. Reset value FC1. The mode is sampled into stage 1 with each input, so a mode change affects only later inputs.
- Fully pipelined, 3 stages. One input is accepted per cycle with no back-pressure. Latency is 3 cycles from in_valid to out_valid.
- S1: s = sext(in_sum) + sext(bias), width ACC_W+1.
- S2, FC1: r = (s<0) ? 0 : s.
- S2, FC2: t = s*21, width ACC_W+7; u = (t >>> 7) + 64, arithmetic shift (floor); r = clamp(u, 0, 128). This approximates hsig = relu6(x+3)/6 in Q7.
- S3: saturate r to [-2^(BITSIZE-1), 2^(BITSIZE-1)-1] and register it to out_data.
- Neuron counter: increments on each out_valid and drives out_addr.
  - It wraps to 0 after index FC1_OUT-1 (FC1) or FC2_OUT-1 (FC2), per the mode tagged to that output.
  - layer_done is asserted in the same cycle as that last out_valid.
- Mode change (tag at S3 differs from previous output's tag): counter restarts at 0 for that output.
- clear: all valid bits, counter and layer_done go to 0 next cycle. Inputs in the clear cycle are dropped. Mode is kept.
- Reset values: out_data=0, out_valid=0, out_addr=0, layer_done=0, busy=0, mode=FC1, all stage registers 0.
- Reset mid-operation discards in-flight data; the first output after reset has out_addr 0.
- Back-to-back inputs across a layer boundary: layer_done on the last neuron, and the next output has addr 0 in the following cycle.

Optional Feature:
- Macro SE_FC_POST_ROUND_EN.
- Defined: FC2 uses u = ((t + 64) >>> 7) + 64 (round half up).
- Undefined: truncating shift as above. FC1 path is unaffected in both cases.

Decomposition:
- Shared package se_pkg holds:
  - constants BITSIZE, FRAC_BITS, ACC_W, FC1_OUT, FC2_OUT, HSIG_MUL=21, HSIG_OFS=64, HSIG_ONE=128;
  - typedef for the mode enum {MODE_FC1, MODE_FC2}.
- One sub-module is natural: se_act_unit, the combinational S2 ReLU/hard-sigmoid plus clamp, reusable elsewhere in the SE path.

Test Plan:
- FC1:
  - in_sum=-300, bias=100 -> out_data=0.
  - in_sum=500, bias=-100 -> 400.
  - in_sum=2^20 -> 8191.
  - Each out_valid arrives exactly 3 cycles after its in_valid.
- FC2 hard-sigmoid:
  - in_sum=0 -> 64.
  - in_sum=384 (3.0) -> 127.
  - in_sum=-1000 -> 0.
  - in_sum=1000 -> 128.
  - in_sum=-1 -> 63 without macro, 64 with SE_FC_POST_ROUND_EN.
- Layer sequencing: 144 consecutive FC1 valids -> out_addr 0..143, layer_done only with addr 143. Then fully_2 plus 576 valids -> addr 0..575, layer_done at 575.
- Mode switch mid-stream: 10 FC1 inputs, then fully_2 and 3 inputs back-to-back -> FC2 outputs use hsig, and the counter restarts at 0 on the first FC2 output.
- clear asserted with 2 inputs in flight -> no out_valid follows, busy=0 next cycle, next input yields addr 0.
- Async rst pulse mid-pipeline -> all outputs 0 immediately; after release, the first output is at addr 0 with mode FC1.

Source files
------------

// File: rtl/se_pkg.sv
// Shared constants, mode type and output saturation helper for the SE-block FC path.
package se_pkg;

    localparam int BITSIZE   = 14;
    localparam int FRAC_BITS = 7;
    localparam int ACC_W     = BITSIZE * 2 - FRAC_BITS + 6;
    localparam int FC1_OUT   = 144;
    localparam int FC2_OUT   = 576;
    localparam int HSIG_MUL  = 21;
    localparam int HSIG_OFS  = 64;
    localparam int HSIG_ONE  = 128;

    typedef enum logic {MODE_FC1, MODE_FC2} mode_t;

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'((1 << (BITSIZE - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W + 1)'(-(1 << (BITSIZE - 1)));

    function automatic logic signed [BITSIZE-1:0] sat_word(input logic signed [ACC_W:0] v);
        if (v > SAT_MAX) begin
            return {1'b0, {(BITSIZE - 1){1'b1}}};
        end else if (v < SAT_MIN) begin
            return {1'b1, {(BITSIZE - 1){1'b0}}};
        end else begin
            return v[BITSIZE-1:0];
        end
    endfunction

endpackage

// File: rtl/se_act_unit.sv
// Combinational ReLU (FC1) / hard-sigmoid (FC2) with clamp.
// Define SE_FC_POST_ROUND_EN to round the hard-sigmoid shift half up instead of truncating.
module se_act_unit
    import se_pkg::*;
(
    input  mode_t                   mode,
    input  logic signed [ACC_W:0]   s,
    output logic signed [ACC_W:0]   r
);

    localparam int TW = ACC_W + 7;
    localparam logic signed [TW-1:0] MUL = TW'(HSIG_MUL);
    localparam logic signed [TW-1:0] OFS = TW'(HSIG_OFS);
    localparam logic signed [TW-1:0] ONE = TW'(HSIG_ONE);
`ifdef SE_FC_POST_ROUND_EN
    localparam logic signed [TW-1:0] RND = TW'(1 << (FRAC_BITS - 1));
`endif

    logic signed [TW-1:0] t;
    logic signed [TW-1:0] u;

    // x*21/128 approximates x/6 in Q7; adding 0.5 gives relu6(x+3)/6 before the clamp
    always_comb begin
        t = $signed({{6{s[ACC_W]}}, s}) * MUL;
`ifdef SE_FC_POST_ROUND_EN
        u = ((t + RND) >>> FRAC_BITS) + OFS;
`else
        u = (t >>> FRAC_BITS) + OFS;
`endif
        r = '0;
        if (mode == MODE_FC1) begin
            r = s[ACC_W] ? '0 : s;
        end else if (u < 0) begin
            r = '0;
        end else if (u > ONE) begin
            r = (ACC_W + 1)'(HSIG_ONE);
        end else begin
            r = u[ACC_W:0];
        end
    end

endmodule

// File: rtl/se_fc_post.sv
// FC post stage: bias add, ReLU/hard-sigmoid, saturation and neuron addressing, 3-cycle pipeline.
// Optional macro SE_FC_POST_ROUND_EN selects rounding in the FC2 hard-sigmoid (see se_act_unit).
module se_fc_post
    import se_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fully_1,
    input  logic                       fully_2,
    input  logic                       clear,
    input  logic signed [ACC_W-1:0]    in_sum,
    input  logic                       in_valid,
    input  logic signed [BITSIZE-1:0]  bias,
    output logic signed [BITSIZE-1:0]  out_data,
    output logic                       out_valid,
    output logic [ADDR_W-1:0]          out_addr,
    output logic                       layer_done,
    output logic                       busy
);

    mode_t                  mode_q, mode_next;
    logic                   s1_valid, s2_valid;
    logic signed [ACC_W:0]  s1_sum, s2_r, act_r;
    mode_t                  s1_mode, s2_mode, last_mode;
    logic [ADDR_W-1:0]      cnt, addr_base, last_idx;

    always_comb begin
        mode_next = mode_q;
        if (fully_1) begin
            mode_next = MODE_FC1;
        end else if (fully_2) begin
            mode_next = MODE_FC2;
        end
    end

    se_act_unit u_act (
        .mode (s1_mode),
        .s    (s1_sum),
        .r    (act_r)
    );

    // A change of layer type between consecutive outputs restarts the neuron index
    always_comb begin
        addr_base = (s2_mode != last_mode) ? '0 : cnt;
        last_idx  = (s2_mode == MODE_FC1) ? ADDR_W'(FC1_OUT - 1) : ADDR_W'(FC2_OUT - 1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q     <= MODE_FC1;
            s1_valid   <= 1'b0;
            s1_sum     <= '0;
            s1_mode    <= MODE_FC1;
            s2_valid   <= 1'b0;
            s2_r       <= '0;
            s2_mode    <= MODE_FC1;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_addr   <= '0;
            layer_done <= 1'b0;
            cnt        <= '0;
            last_mode  <= MODE_FC1;
        end else begin
            mode_q  <= mode_next;
            s1_sum  <= $signed({in_sum[ACC_W-1], in_sum})
                     + $signed({{(ACC_W + 1 - BITSIZE){bias[BITSIZE-1]}}, bias});
            s1_mode <= mode_next;
            s2_r    <= act_r;
            s2_mode <= s1_mode;
            out_data <= sat_word(s2_r);
            if (clear) begin
                s1_valid   <= 1'b0;
                s2_valid   <= 1'b0;
                out_valid  <= 1'b0;
                out_addr   <= '0;
                layer_done <= 1'b0;
                cnt        <= '0;
            end else begin
                s1_valid   <= in_valid;
                s2_valid   <= s1_valid;
                out_valid  <= s2_valid;
                layer_done <= s2_valid && (addr_base == last_idx);
                if (s2_valid) begin
                    out_addr  <= addr_base;
                    cnt       <= (addr_base == last_idx) ? '0 : addr_base + 1'b1;
                    last_mode <= s2_mode;
                end
            end
        end
    end

    assign busy = s1_valid | s2_valid | out_valid;

endmodule

// File: tb/tb_se_fc_post.sv
// Directed self-checking bench for se_fc_post; expected outputs are queued by the stimulus and matched in order.
module tb_se_fc_post;
    import se_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic                       fully_1 = 1'b0;
    logic                       fully_2 = 1'b0;
    logic                       clear = 1'b0;
    logic signed [ACC_W-1:0]    in_sum = '0;
    logic                       in_valid = 1'b0;
    logic signed [BITSIZE-1:0]  bias = '0;
    logic signed [BITSIZE-1:0]  out_data;
    logic                       out_valid;
    logic [9:0]                 out_addr;
    logic                       layer_done;
    logic                       busy;

    typedef struct {
        int data;
        int addr;
        int done;
        int cyc;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

`ifdef SE_FC_POST_ROUND_EN
    localparam int HSIG_M1 = 64;
`else
    localparam int HSIG_M1 = 63;
`endif

    se_fc_post dut (
        .clk        (clk),
        .rst        (rst),
        .fully_1    (fully_1),
        .fully_2    (fully_2),
        .clear      (clear),
        .in_sum     (in_sum),
        .in_valid   (in_valid),
        .bias       (bias),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_addr   (out_addr),
        .layer_done (layer_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    // One accepted input; the expected output is queued with the cycle it was offered in
    task automatic applyStimulus(input int sum, input int b, input int ed, input int ea, input int edone);
        exp_t e;
        e.data = ed;
        e.addr = ea;
        e.done = edone;
        e.cyc  = cyc;
        expq.push_back(e);
        in_sum   = ACC_W'(sum);
        bias     = BITSIZE'(b);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic setMode(input logic fc2);
        fully_1 = !fc2;
        fully_2 = fc2;
        @(posedge clk);
        #1;
        fully_1 = 1'b0;
        fully_2 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || busy) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) checkOutput("drain_timeout", n, 0);
    endtask

    always @(posedge clk) begin
        #2;
        if (out_valid) begin
            if (expq.size() == 0) begin
                checkOutput("spurious_valid", 1, 0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                checkOutput("data", $signed(out_data), e.data);
                checkOutput("addr", out_addr, e.addr);
                checkOutput("layer_done", layer_done, e.done);
                checkOutput("latency", cyc - e.cyc, 3);
            end
        end else if (layer_done) begin
            checkOutput("done_without_valid", 1, 0);
        end
    end

    initial begin
        #3;
        checkOutput("rst_data", $signed(out_data), 0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_addr", out_addr, 0);
        checkOutput("rst_done", layer_done, 0);
        checkOutput("rst_busy", busy, 0);
        #9 rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] FC1 ReLU and saturation");
        setMode(1'b0);
        applyStimulus(-300, 100, 0, 0, 0);
        applyStimulus(500, -100, 400, 1, 0);
        applyStimulus(1 << 20, 0, 8191, 2, 0);
        drain();

        $display("[TB] FC2 hard-sigmoid");
        setMode(1'b1);
        applyStimulus(0, 0, 64, 0, 0);
        applyStimulus(384, 0, 127, 1, 0);
        applyStimulus(-1000, 0, 0, 2, 0);
        applyStimulus(1000, 0, 128, 3, 0);
        applyStimulus(-1, 0, HSIG_M1, 4, 0);
        drain();

        $display("[TB] Full FC1 and FC2 layers");
        setMode(1'b0);
        for (int i = 0; i < FC1_OUT; i++) applyStimulus(i, 0, i, i, (i == FC1_OUT - 1) ? 1 : 0);
        drain();
        setMode(1'b1);
        for (int i = 0; i < FC2_OUT; i++) applyStimulus(0, 0, 64, i, (i == FC2_OUT - 1) ? 1 : 0);
        drain();

        $display("[TB] Mode switch mid-stream");
        setMode(1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(i * 100, 0, i * 100, i, 0);
        setMode(1'b1);
        applyStimulus(0, 0, 64, 0, 0);
        applyStimulus(384, 0, 127, 1, 0);
        applyStimulus(-1, 0, HSIG_M1, 2, 0);
        drain();

        $display("[TB] Clear with inputs in flight");
        in_sum   = ACC_W'(384);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        checkOutput("clear_busy", busy, 0);
        checkOutput("clear_addr", out_addr, 0);
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(0, 0, 64, 0, 0);
        drain();

        $display("[TB] Async reset mid-pipeline");
        applyStimulus(0, 0, 64, 1, 0);
        applyStimulus(0, 0, 64, 2, 0);
        #2;
        rst = 1'b0;
        expq.delete();
        #1;
        checkOutput("arst_data", $signed(out_data), 0);
        checkOutput("arst_valid", out_valid, 0);
        checkOutput("arst_addr", out_addr, 0);
        checkOutput("arst_busy", busy, 0);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(500, 0, 500, 0, 0);
        drain();

        checkOutput("queue_empty", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
